// File: rtl/water_led_chk.sv
// Walking-LED sequence checker: decodes an active-low one-hot LED bus, checks rotation order and step timing.
// Optional LED_CHK_SYNC_EN adds a 2-flop input synchronizer (reset to LEDs off) ahead of the sample register.
module water_led_chk #(
  parameter logic [24:0] CNT_MAX = 25'd24_999_999,
  parameter logic [24:0] TOL     = 25'd1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] led_in,
  output logic [3:0] pattern_out,
  output logic       locked,
  output logic       err_pattern,
  output logic       err_timing,
  output logic [7:0] err_cnt
);

  localparam logic [25:0] CNT_SAT = {1'b0, CNT_MAX} + {1'b0, TOL} + 26'd1;
  localparam logic [25:0] WIN_LO  = {1'b0, CNT_MAX} - {1'b0, TOL};
  localparam logic [25:0] WIN_HI  = {1'b0, CNT_MAX} + {1'b0, TOL};

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  logic [3:0]  led_src_s;
  logic [3:0]  led_q_r;
  logic [3:0]  led_prev_r;
  logic [25:0] cnt_r;
  state_t      state_r;
  state_t      state_next_s;
  logic        change_s;
  logic        cnt_sat_s;
  logic        in_win_s;
  logic        valid_s;
  logic        succ_ok_s;
  logic        err_pattern_s;
  logic        err_timing_s;
  logic        locked_r;
  logic        err_pattern_r;
  logic        err_timing_r;
  logic [7:0]  err_cnt_r;

`ifdef LED_CHK_SYNC_EN
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;

  // Two-stage synchronizer; resets to all LEDs off (active-low bus high).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= led_in;
      sync2_r <= sync1_r;
    end
  end

  assign led_src_s = sync2_r;
`else
  assign led_src_s = led_in;
`endif

  // Sample register (inverted to active-high) and its one-clock history.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q_r    <= 4'b0000;
      led_prev_r <= 4'b0000;
    end else begin
      led_q_r    <= ~led_src_s;
      led_prev_r <= led_q_r;
    end
  end

  // Pattern-change, window and successor decode.
  always_comb begin
    change_s  = (led_q_r != led_prev_r);
    cnt_sat_s = (cnt_r == CNT_SAT);
    in_win_s  = (cnt_r >= WIN_LO) && (cnt_r <= WIN_HI);
    valid_s   = is_onehot(led_q_r);
    succ_ok_s = valid_s && (led_q_r == rotl1(led_prev_r));
  end

  // Interval counter: clears on a change, otherwise counts up and sticks at saturation.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_r <= 26'd0;
    end else if (change_s) begin
      cnt_r <= 26'd0;
    end else if (cnt_sat_s) begin
      cnt_r <= cnt_r;
    end else begin
      cnt_r <= cnt_r + 26'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HUNT: begin
        if (change_s && valid_s) begin
          state_next_s = SYNC;
        end else begin
          state_next_s = HUNT;
        end
      end
      SYNC, LOCK: begin
        if (change_s) begin
          state_next_s = (succ_ok_s && in_win_s) ? LOCK : HUNT;
        end else if (cnt_sat_s) begin
          state_next_s = HUNT;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = HUNT;
      end
    endcase
  end

  // FSM error outputs: only a broken sequence while locked is reported.
  always_comb begin
    err_pattern_s = 1'b0;
    err_timing_s  = 1'b0;
    case (state_r)
      LOCK: begin
        if (change_s) begin
          err_pattern_s = !succ_ok_s;
          err_timing_s  = !in_win_s;
        end else begin
          err_timing_s  = cnt_sat_s;
        end
      end
      default: begin
        err_pattern_s = 1'b0;
        err_timing_s  = 1'b0;
      end
    endcase
  end

  // Registered status, pulses and saturating error counter (one increment per error cycle).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      locked_r      <= 1'b0;
      err_pattern_r <= 1'b0;
      err_timing_r  <= 1'b0;
      err_cnt_r     <= 8'd0;
    end else begin
      locked_r      <= (state_next_s == LOCK);
      err_pattern_r <= err_pattern_s;
      err_timing_r  <= err_timing_s;
      if ((err_pattern_s || err_timing_s) && (err_cnt_r != 8'd255)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign pattern_out = led_q_r;
  assign locked      = locked_r;
  assign err_pattern = err_pattern_r;
  assign err_timing  = err_timing_r;
  assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_water_led_chk.sv
// Directed bench for water_led_chk (CNT_MAX=9, TOL=1); with LED_CHK_SYNC_EN only the lock/wrap table runs, checked 2 clocks late.
module tb_water_led_chk;

  localparam logic [24:0] CNT_MAX = 25'd9;
  localparam logic [24:0] TOL     = 25'd1;
`ifdef LED_CHK_SYNC_EN
  localparam int LAT = 2;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] led_in = 4'b1111;
  logic [3:0] pattern_out;
  logic       locked;
  logic       err_pattern;
  logic       err_timing;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] led;
    int         hold;
    logic [3:0] pat;
    logic       lk;
    logic       ep;
    logic       et;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs [15];

  water_led_chk #(.CNT_MAX(CNT_MAX), .TOL(TOL)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .led_in      (led_in),
    .pattern_out (pattern_out),
    .locked      (locked),
    .err_pattern (err_pattern),
    .err_timing  (err_timing),
    .err_cnt     (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] l, input int n);
    led_in = l;
    step(n);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] pat, input logic lk,
                         input logic ep, input logic et, input logic [7:0] ec);
    chk({tag, ".pattern_out"}, {4'd0, pattern_out}, {4'd0, pat});
    chk({tag, ".locked"}, {7'd0, locked}, {7'd0, lk});
    chk({tag, ".err_pattern"}, {7'd0, err_pattern}, {7'd0, ep});
    chk({tag, ".err_timing"}, {7'd0, err_timing}, {7'd0, et});
    chk({tag, ".err_cnt"}, err_cnt, ec);
  endtask

  task automatic chk_vec(input int idx, input vec_t v);
    chk_all($sformatf("vec%0d", idx), v.pat, v.lk, v.ep, v.et, v.ec);
  endtask

  initial begin
    // Lock and wrap, then a wrong successor (0001 -> 0100) with an in-window interval.
    vecs[0]  = '{4'b1110, 1, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{4'b1110, 9, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{4'b1101, 1, 4'b0010, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{4'b1101, 1, 4'b0010, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{4'b1101, 8, 4'b0010, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{4'b1011, 1, 4'b0100, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{4'b1011, 9, 4'b0100, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{4'b0111, 1, 4'b1000, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{4'b0111, 9, 4'b1000, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{4'b1110, 1, 4'b0001, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{4'b1110, 1, 4'b0001, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{4'b1110, 8, 4'b0001, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{4'b1011, 1, 4'b0100, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{4'b1011, 1, 4'b0100, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[14] = '{4'b1011, 1, 4'b0100, 1'b0, 1'b0, 1'b0, 8'd1};

    sys_rst_n = 1'b0;
    led_in    = 4'b1111;
    step(3);
    chk_all("in_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    sys_rst_n = 1'b1;
    step(2);
    chk_all("after_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].led, vecs[i].hold);
`ifdef LED_CHK_SYNC_EN
      fork
        automatic int   idx = i;
        automatic vec_t v   = vecs[i];
        begin
          repeat (LAT) @(posedge sys_clk);
          #1;
          chk_vec(idx, v);
        end
      join_none
`else
      chk_vec(i, vecs[i]);
`endif
    end

`ifdef LED_CHK_SYNC_EN
    step(LAT + 2);
`else
    // Window boundaries: relock, then an 11-clock interval (accepted) and a 12-clock one (rejected).
    drive(4'b0111, 10);
    drive(4'b1110, 11);
    chk_all("win_lock", 4'b0001, 1'b1, 1'b0, 1'b0, 8'd1);
    drive(4'b1101, 1);
    drive(4'b1101, 1);
    chk_all("win_11", 4'b0010, 1'b1, 1'b0, 1'b0, 8'd1);
    drive(4'b1101, 10);
    drive(4'b1011, 1);
    step(1);
    chk_all("win_12", 4'b0100, 1'b0, 1'b0, 1'b1, 8'd2);

    // Stall while locked: timeout pulse once the counter saturates, then silence in HUNT.
    drive(4'b0111, 10);
    drive(4'b1110, 1);
    step(1);
    chk_all("stall_lock", 4'b0001, 1'b1, 1'b0, 1'b0, 8'd2);
    step(11);
    chk_all("stall_pre", 4'b0001, 1'b1, 1'b0, 1'b0, 8'd2);
    step(1);
    chk_all("stall_hit", 4'b0001, 1'b0, 1'b0, 1'b1, 8'd3);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("stall_quiet.err_timing", {7'd0, err_timing}, 8'd0);
      chk("stall_quiet.err_cnt", err_cnt, 8'd3);
    end

    // Error injection: wrong successor with a 2-clock interval raises both pulses, counted once.
    for (int n = 0; n < 300; n++) begin
      drive(4'b1101, 10);
      drive(4'b1011, 2);
      if (n == 0) chk("inj_locked", {7'd0, locked}, 8'd1);
      drive(4'b1110, 1);
      step(1);
      if (n == 0) chk_all("both_err", 4'b0001, 1'b0, 1'b1, 1'b1, 8'd4);
      step(1);
      if (n == 0) chk_all("both_after", 4'b0001, 1'b0, 1'b0, 1'b0, 8'd4);
    end
    chk("err_cnt_sat", err_cnt, 8'd255);

    // Reset while locked.
    drive(4'b1101, 10);
    drive(4'b1011, 2);
    chk_all("pre_reset_lock", 4'b0100, 1'b1, 1'b0, 1'b0, 8'd255);
    sys_rst_n = 1'b0;
    #1;
    chk_all("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1);
    chk_all("mid_reset_clk", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    sys_rst_n = 1'b1;
    step(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
